// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter that sits right after the execution units. Each cycle it
// scans every FU response slot, starting at the round-robin pointer. Slots
// holding ops younger than an active redirect are claimed and dropped. Up to
// `wwd` of the remaining valid slots are claimed and registered onto the
// writeback bus.
//
// Handshake: a slot is offered while fu_resp[f][s].opid[15] is set, and it is
// taken only in a cycle where fu_claim[f][s] is high. The FU keeps presenting
// an unclaimed slot unchanged. A claim is never raised for an invalid slot,
// and a slot is claimed at most once per cycle.
//
// Optional feature: define WB_ARBITER_STATS_EN to add the perf_grants and
// perf_conflicts counters. Arbitration is the same with or without it.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   redir          redirect bundle (opid[15] = valid, topid = oldest in flight)
//   stall          writeback consumer stall; no grants while high
//   fu_resp        [nfu][ewd] FU result slots, valid = opid[15]
//   fu_claim       [nfu][ewd] combinational claim, same cycle as grant/squash
//   wb             [wwd] registered writeback results, valid = opid[15]
//   perf_grants    (stats build) ops granted onto wb, wrapping
//   perf_conflicts (stats build) unstalled cycles with more eligible slots than wwd
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;
    typedef struct packed {
        logic [15:0] opid;
        logic [31:0] data;
    } exe_bundle_t;

    typedef struct packed {
        logic [15:0] opid;
        logic [15:0] topid;
    } red_bundle_t;
endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int nfu  = 4,
    parameter int ewd  = 2,
    parameter int wwd  = 2,
    parameter int opsz = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  red_bundle_t              redir,
    input  logic                     stall,
    input  exe_bundle_t              fu_resp [nfu][ewd],
    output logic [nfu-1:0][ewd-1:0]  fu_claim,
    output exe_bundle_t              wb [wwd]
`ifdef WB_ARBITER_STATS_EN
    ,
    output logic [31:0]              perf_grants,
    output logic [31:0]              perf_conflicts
`endif
);

    localparam int OW = $clog2(opsz);
    localparam int RW = (nfu > 1) ? $clog2(nfu) : 1;

    // Age is measured as distance from topid, so the comparison survives
    // wrap-around of the opid space. An op is younger only if it lies
    // strictly beyond the redirecting op.
    function automatic logic younger(input logic [15:0] x, input red_bundle_t r);
        logic [OW-1:0] xd;
        logic [OW-1:0] rd;
        xd = x[OW-1:0] - r.topid[OW-1:0];
        rd = r.opid[OW-1:0] - r.topid[OW-1:0];
        return r.opid[15] & x[15] & (xd > rd);
    endfunction

    logic [RW-1:0]          rr_ptr;
    logic [RW-1:0]          rr_next;
    exe_bundle_t            wb_q    [wwd];
    exe_bundle_t            wb_next [wwd];
    logic [nfu-1:0][ewd-1:0] claim_c;
    int                     n_grant;
    int                     n_elig;
    int                     fidx;

    // Only the low OW bits of the ids take part in ordering.
    logic unused_bits;
    assign unused_bits = ^{redir.opid[14:OW], redir.topid[15:OW]};

    // Selection: rotate through the FUs from rr_ptr. Within each FU, take
    // slots in index order. Squashed slots are claimed but take no bandwidth.
    always_comb begin
        claim_c = '0;
        n_grant = 0;
        n_elig  = 0;
        fidx    = 0;
        rr_next = rr_ptr;
        for (int i = 0; i < wwd; i++) wb_next[i] = '0;
        for (int k = 0; k < nfu; k++) begin
            fidx = (int'(rr_ptr) + k) % nfu;
            for (int s = 0; s < ewd; s++) begin
                if (fu_resp[fidx][s].opid[15]) begin
                    if (younger(fu_resp[fidx][s].opid, redir)) begin
                        claim_c[fidx][s] = 1'b1;
                    end else begin
                        n_elig = n_elig + 1;
                        if (!stall && n_grant < wwd) begin
                            claim_c[fidx][s] = 1'b1;
                            wb_next[n_grant] = fu_resp[fidx][s];
                            n_grant          = n_grant + 1;
                            rr_next          = RW'((fidx + 1) % nfu);
                        end
                    end
                end
            end
        end
    end

    // No claims while reset is held, so nothing an FU presents is lost.
    assign fu_claim = rst ? '0 : claim_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int i = 0; i < wwd; i++) wb_q[i] <= '0;
        end else if (stall) begin
            // Hold the bus, but drop held entries that a redirect has squashed.
            for (int i = 0; i < wwd; i++) begin
                if (younger(wb_q[i].opid, redir)) wb_q[i].opid <= '0;
            end
        end else begin
            for (int i = 0; i < wwd; i++) wb_q[i] <= wb_next[i];
            rr_ptr <= rr_next;
        end
    end

    // A redirect that arrives one cycle after the grant must still stop the op
    // from retiring, so the bus is also masked combinationally.
    always_comb begin
        for (int i = 0; i < wwd; i++) begin
            wb[i] = wb_q[i];
            if (younger(wb_q[i].opid, redir)) wb[i].opid = '0;
        end
    end

`ifdef WB_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grants    <= '0;
            perf_conflicts <= '0;
        end else if (!stall) begin
            perf_grants <= perf_grants + 32'(n_grant);
            if (n_elig > wwd) perf_conflicts <= perf_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter. Expected bus contents are queued when the
// stimulus is driven and then drained when the bus is sampled.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int W = $bits(exe_bundle_t);

    logic         clk;
    logic         rst;
    red_bundle_t  redir;
    logic         stall;
    exe_bundle_t  fu_resp [4][2];
    logic [3:0][1:0] fu_claim;
    exe_bundle_t  wb [2];

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .redir    (redir),
        .stall    (stall),
        .fu_resp  (fu_resp),
        .fu_claim (fu_claim),
        .wb       (wb)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // drivers
    function automatic exe_bundle_t mk(input logic [15:0] op);
        exe_bundle_t e;
        e.opid = op;
        e.data = {16'hD0D0, op};
        return e;
    endfunction

    function automatic exe_bundle_t mkm(input logic [15:0] op);
        exe_bundle_t e;
        e = mk(op);
        e.opid = '0;
        return e;
    endfunction

    task automatic clear_resp();
        for (int f = 0; f < 4; f++)
            for (int s = 0; s < 2; s++) fu_resp[f][s] = '0;
    endtask

    task automatic set_redir(input logic [15:0] op, input logic [15:0] top);
        redir.opid  = op;
        redir.topid = top;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_claim(input string tag, input logic [7:0] expv);
        chk({tag, "_claim"}, 64'(fu_claim), 64'(expv));
    endtask

    task automatic check_wb(input string tag);
        logic [W-1:0] e;
        for (int i = 0; i < 2; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk($sformatf("%s_wb%0d", tag, i), 64'(wb[i]), 64'(e));
        end
    endtask

    task automatic check_rr(input string tag, input logic [1:0] expv);
        chk({tag, "_rr"}, 64'(dut.rr_ptr), 64'(expv));
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        redir = '0;
        clear_resp();
        fu_resp[0][0] = mk(16'h8099);
        tick();
        check_claim("rst", 8'h00);
        tick();
        check_wb("rst");
        check_rr("rst", 2'd0);
        rst = 1'b0;
        clear_resp();

        // single result on the last FU
        fu_resp[3][0] = mk(16'h8005);
        #1 check_claim("t1", 8'h40);
        exp_q.push_back(mk(16'h8005));
        tick();
        check_wb("t1");
        check_rr("t1", 2'd0);
        clear_resp();

        // three eligible, two lanes: FU1 waits a cycle
        fu_resp[0][0] = mk(16'h8001);
        fu_resp[0][1] = mk(16'h8002);
        fu_resp[1][0] = mk(16'h8003);
        #1 check_claim("t2a", 8'h03);
        exp_q.push_back(mk(16'h8001));
        exp_q.push_back(mk(16'h8002));
        tick();
        check_wb("t2a");
        check_rr("t2a", 2'd1);
        fu_resp[0][0] = '0;
        fu_resp[0][1] = '0;
        #1 check_claim("t2b", 8'h04);
        exp_q.push_back(mk(16'h8003));
        tick();
        check_wb("t2b");
        check_rr("t2b", 2'd2);
        clear_resp();

        // rotation from rr_ptr=2 wraps past FU3 back to FU0
        fu_resp[0][0] = mk(16'h8004);
        fu_resp[2][0] = mk(16'h8007);
        fu_resp[3][1] = mk(16'h8006);
        #1 check_claim("rot_a", 8'h90);
        exp_q.push_back(mk(16'h8007));
        exp_q.push_back(mk(16'h8006));
        tick();
        check_wb("rot_a");
        check_rr("rot_a", 2'd0);
        fu_resp[2][0] = '0;
        fu_resp[3][1] = '0;
        #1 check_claim("rot_b", 8'h01);
        exp_q.push_back(mk(16'h8004));
        tick();
        check_wb("rot_b");
        check_rr("rot_b", 2'd1);
        clear_resp();
        #1 check_claim("idle", 8'h00);
        tick();
        check_wb("idle");
        check_rr("idle", 2'd1);

        // squash: younger slot claimed and dropped, equal-age slot granted
        set_redir(16'h8010, 16'h8000);
        fu_resp[2][0] = mk(16'h8012);
        #1 check_claim("t3a", 8'h10);
        tick();
        check_wb("t3a");
        check_rr("t3a", 2'd1);
        clear_resp();
        fu_resp[2][1] = mk(16'h8010);
        #1 check_claim("t3b", 8'h20);
        exp_q.push_back(mk(16'h8010));
        tick();
        check_wb("t3b");
        check_rr("t3b", 2'd3);
        clear_resp();

        // wrap-around age compare
        set_redir(16'h803F, 16'h803E);
        fu_resp[1][0] = mk(16'h8001);
        fu_resp[1][1] = mk(16'h803E);
        #1 check_claim("t4", 8'h0C);
        exp_q.push_back(mk(16'h803E));
        tick();
        check_wb("t4");
        check_rr("t4", 2'd2);
        clear_resp();
        redir = '0;

        // stall for three cycles; squash claims still happen
        stall = 1'b1;
        fu_resp[0][0] = mk(16'h8030);
        #1 check_claim("t5s1", 8'h00);
        exp_q.push_back(mk(16'h803E));
        tick();
        check_wb("t5s1");
        check_rr("t5s1", 2'd2);
        set_redir(16'h803F, 16'h8030);
        fu_resp[3][0] = mk(16'h8040);
        #1 check_claim("t5s2", 8'h40);
        exp_q.push_back(mk(16'h803E));
        tick();
        check_wb("t5s2");
        redir = '0;
        fu_resp[3][0] = '0;
        #1 check_claim("t5s3", 8'h00);
        exp_q.push_back(mk(16'h803E));
        tick();
        check_wb("t5s3");
        check_rr("t5s3", 2'd2);
        stall = 1'b0;
        #1 check_claim("t5go", 8'h01);
        exp_q.push_back(mk(16'h8030));
        tick();
        check_wb("t5go");
        check_rr("t5go", 2'd1);
        clear_resp();

        // redirect one cycle after grant masks the bus
        fu_resp[1][0] = mk(16'h8020);
        #1 check_claim("t6", 8'h04);
        exp_q.push_back(mk(16'h8020));
        tick();
        check_wb("t6");
        clear_resp();
        set_redir(16'h801F, 16'h8000);
        #1;
        exp_q.push_back(mkm(16'h8020));
        check_wb("t6_mask");
        tick();
        check_wb("t6_empty");
        check_rr("t6", 2'd2);
        redir = '0;

        // squash of a held entry during stall is stored in the register
        fu_resp[2][0] = mk(16'h8021);
        #1 check_claim("t7", 8'h10);
        exp_q.push_back(mk(16'h8021));
        tick();
        check_wb("t7");
        clear_resp();
        stall = 1'b1;
        set_redir(16'h801F, 16'h8000);
        #1;
        exp_q.push_back(mkm(16'h8021));
        check_wb("t7_mask");
        tick();
        redir = '0;
        #1;
        exp_q.push_back(mkm(16'h8021));
        check_wb("t7_reg");
        check_rr("t7", 2'd3);
        stall = 1'b0;

        // reset mid-operation
        fu_resp[0][0] = mk(16'h8022);
        rst = 1'b1;
        #1 check_claim("t8rst", 8'h00);
        tick();
        check_wb("t8rst");
        check_rr("t8rst", 2'd0);
        rst = 1'b0;
        #1 check_claim("t8", 8'h01);
        exp_q.push_back(mk(16'h8022));
        tick();
        check_wb("t8");
        check_rr("t8", 2'd1);
        clear_resp();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
